pipeline_sequencer: RTL and testbench

//  Parametrised stage sequencer for the multi-stage core; replaces the fixed 4-stage counter,

---
 rtl/pipeline_sequencer.sv | 159 +++++++++++++++
 tb/tb_pipeline_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
//   Parametrised stage sequencer for the multi-stage core. It produces a
//   clock-enable (advance) for all stage registers instead of gating the
//   clock. It also tracks the current stage, counts retired instructions
//   with saturation, and holds a sticky error halt.
//
//   Optional feature: define SINGLE_STEP_EN to add the step_mode/step_request
//   debug ports. With the ports present, one request grants exactly one
//   instruction (NUM_STAGES advances).
//
// Parameters
//   NUM_STAGES     stages per instruction (>=2); stage NUM_STAGES-1 is writeback
//   INITIAL_DELAY  cycles after reset with advance held low (0 = none)
//   COUNT_W        width of retired_count
//
// Ports
//   clk            system clock, all logic on posedge
//   reset          synchronous, active-high
//   stall_request  hold current stage (memory stall), level-sensitive
//   error_in       fault from error_propagation, level-sensitive
//   step_mode      [SINGLE_STEP_EN] 1 = single-step gating active
//   step_request   [SINGLE_STEP_EN] one-cycle pulse grants one instruction
//   advance        clock enable: stage registers update this cycle
//   stage_onehot   one-hot current stage
//   current_stage  binary current stage
//   commit         writeback retires this cycle
//   halted         sticky error halt
//   warmup         high while in initial delay
//   retired_count  instructions committed since reset (saturating)
// ---------------------------------------------------------------------------
module pipeline_sequencer #(
    parameter int NUM_STAGES    = 4,
    parameter int INITIAL_DELAY = 0,
    parameter int COUNT_W       = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall_request,
    input  logic                          error_in,
`ifdef SINGLE_STEP_EN
    input  logic                          step_mode,
    input  logic                          step_request,
`endif
    output logic                          advance,
    output logic [NUM_STAGES-1:0]         stage_onehot,
    output logic [$clog2(NUM_STAGES)-1:0] current_stage,
    output logic                          commit,
    output logic                          halted,
    output logic                          warmup,
    output logic [COUNT_W-1:0]            retired_count
);

    localparam int STAGE_W = $clog2(NUM_STAGES);
    localparam int DELAY_W = (INITIAL_DELAY > 1) ? $clog2(INITIAL_DELAY) : 1;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [STAGE_W-1:0] STAGE_ONE  = STAGE_W'(1);
    localparam logic [DELAY_W-1:0] DELAY_LAST =
        DELAY_W'((INITIAL_DELAY > 0) ? INITIAL_DELAY - 1 : 0);
    localparam logic [DELAY_W-1:0] DELAY_ONE  = DELAY_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);
    localparam logic               WARMUP_RST = (INITIAL_DELAY != 0);

    logic [STAGE_W-1:0] stage_q,   stage_d;
    logic [DELAY_W-1:0] delay_q,   delay_d;
    logic               warmup_q,  warmup_d;
    logic               halted_q,  halted_d;
    logic [COUNT_W-1:0] retired_q, retired_d;
    logic               step_ok;
    logic               last_stage;

`ifdef SINGLE_STEP_EN
    logic               token_q,   token_d;
`endif

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        step_ok = 1'b1;
`ifdef SINGLE_STEP_EN
        step_ok = !step_mode || token_q;
`endif
        last_stage = (stage_q == LAST_STAGE);

        // Reset is folded in so the enable is never high while the
        // registers are being forced back to their reset state.
        advance = !reset && !warmup_q && !halted_q && !error_in
                  && !stall_request && step_ok;
        commit  = advance && last_stage;

        stage_d = stage_q;
        if (advance) begin
            stage_d = last_stage ? '0 : stage_q + STAGE_ONE;
        end

        // warmup drops on the edge where the counter reaches INITIAL_DELAY-1,
        // giving exactly INITIAL_DELAY cycles with advance low.
        delay_d  = delay_q;
        warmup_d = warmup_q;
        if (warmup_q) begin
            delay_d = delay_q + DELAY_ONE;
            if (delay_q == DELAY_LAST) begin
                warmup_d = 1'b0;
            end
        end

        // Faults during warmup are ignored; otherwise halt is sticky.
        halted_d = halted_q || (error_in && !warmup_q);

        retired_d = retired_q;
        if (commit && !(&retired_q)) begin
            retired_d = retired_q + COUNT_ONE;
        end

`ifdef SINGLE_STEP_EN
        // A request wins over a coinciding commit so it is never lost.
        token_d = token_q;
        if (step_request) begin
            token_d = 1'b1;
        end else if (commit) begin
            token_d = 1'b0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        // NOTE: the design has no memory arrays; every flop has a reset value
        // so the sequencer restarts cleanly from stage 0.
        if (reset) begin
            stage_q   <= '0;
            delay_q   <= '0;
            warmup_q  <= WARMUP_RST;
            halted_q  <= 1'b0;
            retired_q <= '0;
`ifdef SINGLE_STEP_EN
            token_q   <= 1'b0;
`endif
        end else begin
            stage_q   <= stage_d;
            delay_q   <= delay_d;
            warmup_q  <= warmup_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
`ifdef SINGLE_STEP_EN
            token_q   <= token_d;
`endif
        end
    end

    assign current_stage = stage_q;
    assign stage_onehot  = NUM_STAGES'(1) << stage_q;
    assign warmup        = warmup_q;
    assign halted        = halted_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pipeline_sequencer
//   Directed bench for pipeline_sequencer.
//   Instance a: NUM_STAGES=4, INITIAL_DELAY=3, COUNT_W=3 (warmup, stall, halt,
//   reset and saturation).
//   Instance b: NUM_STAGES=5, INITIAL_DELAY=0, COUNT_W=8 (no warmup, 5-stage
//   wrap).
//   With SINGLE_STEP_EN defined, both instances also get single-step checks.
// ---------------------------------------------------------------------------
module tb_pipeline_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance a
    logic       rst_a, stall_a, err_a;
    logic       adv_a, commit_a, halted_a, warmup_a;
    logic [3:0] onehot_a;
    logic [1:0] stage_a;
    logic [2:0] rc_a;
    // instance b
    logic       rst_b, stall_b, err_b;
    logic       adv_b, commit_b, halted_b, warmup_b;
    logic [4:0] onehot_b;
    logic [2:0] stage_b;
    logic [7:0] rc_b;
`ifdef SINGLE_STEP_EN
    logic       smode_a, sreq_a, smode_b, sreq_b;
`endif

    pipeline_sequencer #(.NUM_STAGES(4), .INITIAL_DELAY(3), .COUNT_W(3)) dut_a (
        .clk           (clk),
        .reset         (rst_a),
        .stall_request (stall_a),
        .error_in      (err_a),
`ifdef SINGLE_STEP_EN
        .step_mode     (smode_a),
        .step_request  (sreq_a),
`endif
        .advance       (adv_a),
        .stage_onehot  (onehot_a),
        .current_stage (stage_a),
        .commit        (commit_a),
        .halted        (halted_a),
        .warmup        (warmup_a),
        .retired_count (rc_a)
    );

    pipeline_sequencer #(.NUM_STAGES(5), .INITIAL_DELAY(0), .COUNT_W(8)) dut_b (
        .clk           (clk),
        .reset         (rst_b),
        .stall_request (stall_b),
        .error_in      (err_b),
`ifdef SINGLE_STEP_EN
        .step_mode     (smode_b),
        .step_request  (sreq_b),
`endif
        .advance       (adv_b),
        .stage_onehot  (onehot_b),
        .current_stage (stage_b),
        .commit        (commit_b),
        .halted        (halted_b),
        .warmup        (warmup_b),
        .retired_count (rc_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Settle 1 ns after inputs change, then compare every output of a.
    task automatic chk_a(input string tag, input logic adv, input int stg,
                         input logic cmt, input logic hlt, input logic wu, input int rc);
        #1;
        chk({tag, ".advance"}, 32'(adv_a),    32'(adv));
        chk({tag, ".stage"},   32'(stage_a),  32'(stg));
        chk({tag, ".onehot"},  32'(onehot_a), 32'(1) << stg);
        chk({tag, ".commit"},  32'(commit_a), 32'(cmt));
        chk({tag, ".halted"},  32'(halted_a), 32'(hlt));
        chk({tag, ".warmup"},  32'(warmup_a), 32'(wu));
        chk({tag, ".retired"}, 32'(rc_a),     32'(rc));
    endtask

    task automatic chk_b(input string tag, input logic adv, input int stg,
                         input logic cmt, input int rc);
        #1;
        chk({tag, ".advance"}, 32'(adv_b),    32'(adv));
        chk({tag, ".stage"},   32'(stage_b),  32'(stg));
        chk({tag, ".onehot"},  32'(onehot_b), 32'(1) << stg);
        chk({tag, ".commit"},  32'(commit_b), 32'(cmt));
        chk({tag, ".halted"},  32'(halted_b), 32'd0);
        chk({tag, ".warmup"},  32'(warmup_b), 32'd0);
        chk({tag, ".retired"}, 32'(rc_b),     32'(rc));
    endtask

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_rc;
        rst_a = 1'b1; stall_a = 1'b0; err_a = 1'b0;
        rst_b = 1'b1; stall_b = 1'b0; err_b = 1'b0;
`ifdef SINGLE_STEP_EN
        smode_a = 1'b0; sreq_a = 1'b0; smode_b = 1'b0; sreq_b = 1'b0;
`endif
        tick();
        tick();
        // reset held: stage 0, warmup pending, advance forced low
        chk_a("rst", 0, 0, 0, 0, 1, 0);

        // warmup: advance low for cycles 0-2, first commit in cycle 6
        rst_a = 1'b0;
        for (int c = 0; c < 7; c++) begin
            chk_a($sformatf("wu%0d", c), c >= 3, (c < 3) ? 0 : c - 3, c == 6, 0, c < 3, 0);
            tick();
        end
        chk_a("wrap", 1, 0, 0, 0, 0, 1);
        tick();
        chk_a("s1", 1, 1, 0, 0, 0, 1);
        tick();

        // stall 5 cycles at stage 2
        stall_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk_a($sformatf("stall%0d", k), 0, 2, 0, 0, 0, 1);
            tick();
        end
        stall_a = 1'b0;
        chk_a("resume", 1, 2, 0, 0, 0, 1);
        tick();
        chk_a("s3", 1, 3, 1, 0, 0, 1);
        tick();
        chk_a("s0", 1, 0, 0, 0, 0, 2);
        tick();

        // one-cycle error at stage 1: halt registers next cycle and sticks
        err_a = 1'b1;
        chk_a("err", 0, 1, 0, 0, 0, 2);
        tick();
        err_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_a($sformatf("halt%0d", k), 0, 1, 0, 1, 0, 2);
            tick();
        end

        // reset clears the halt and re-enters warmup
        rst_a = 1'b1;
        chk_a("rst2", 0, 1, 0, 1, 0, 2);
        tick();
        rst_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_a($sformatf("wu2_%0d", c), 0, 0, 0, 0, 1, 0);
            tick();
        end
        for (int s = 0; s < 3; s++) begin
            chk_a($sformatf("run%0d", s), 1, s, 0, 0, 0, 0);
            tick();
        end

        // error together with stall on the last stage: no commit, halt set
        err_a = 1'b1;
        stall_a = 1'b1;
        chk_a("err_last", 0, 3, 0, 0, 0, 0);
        tick();
        err_a = 1'b0;
        chk_a("halt_last", 0, 3, 0, 1, 0, 0);
        tick();

        // reset at stage 3 with stall and halt active
        rst_a = 1'b1;
        chk_a("rst3_in", 0, 3, 0, 1, 0, 0);
        tick();
        rst_a = 1'b0;
        stall_a = 1'b0;
        chk_a("rst3", 0, 0, 0, 0, 1, 0);
        tick();
        for (int c = 1; c < 3; c++) begin
            chk_a($sformatf("wu3_%0d", c), 0, 0, 0, 0, 1, 0);
            tick();
        end

        // 10 instructions with a 3-bit counter: 1..7 then hold at 7
        exp_rc = 0;
        for (int i = 0; i < 10; i++) begin
            for (int s = 0; s < 4; s++) begin
                chk_a($sformatf("sat%0d_%0d", i, s), 1, s, s == 3, 0, 0, exp_rc);
                tick();
                if (s == 3 && exp_rc < 7) exp_rc++;
            end
        end
`ifdef SINGLE_STEP_EN
        // one request -> exactly 4 advances and 1 commit, then idle
        smode_a = 1'b1;
        chk_a("step_idle", 0, 0, 0, 0, 0, 7);
        tick();
        sreq_a = 1'b1;
        chk_a("step_req", 0, 0, 0, 0, 0, 7);
        tick();
        sreq_a = 1'b0;
        for (int s = 0; s < 4; s++) begin
            chk_a($sformatf("step%0d", s), 1, s, s == 3, 0, 0, 7);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            chk_a($sformatf("step_done%0d", k), 0, 0, 0, 0, 0, 7);
            tick();
        end
`else
        chk_a("sat_end", 1, 0, 0, 0, 0, 7);
        tick();
`endif

        // instance b: no warmup, 5-stage wrap
        rst_b = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk_b($sformatf("b%0d", c), 1, c % 5, (c % 5) == 4, c / 5);
            tick();
        end
`ifdef SINGLE_STEP_EN
        smode_b = 1'b1;
        chk_b("b_step_idle", 0, 0, 0, 2);
        tick();
        sreq_b = 1'b1;
        chk_b("b_step_req", 0, 0, 0, 2);
        tick();
        sreq_b = 1'b0;
        for (int s = 0; s < 5; s++) begin
            chk_b($sformatf("b_step%0d", s), 1, s, s == 4, 2);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            chk_b($sformatf("b_step_done%0d", k), 0, 0, 0, 3);
            tick();
        end
`else
        chk_b("b_end", 1, 0, 0, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
